przebieg_detektor: RTL and testbench
====================================

Name: przebieg_detektor

Overview:
- Receive-side counterpart of the 12-step LED waveform generator: samples a serial 1-bit waveform, recovers symbol timing and recognises the fixed 12-symbol pattern.
- Sits on the input side of a board; fed from another board's LED/GPIO line.
- Reports pattern matches, lock status and symbol errors.

Parameters:
- CLK_PER_SYM, 2000000, iCLK cycles per symbol; must match the transmitter's symbol period; minimum 4.
- PATTERN, 12'hCE8, expected sequence; bit i is symbol i in time order (0,0,0,1,0,1,1,1,0,0,1,1).
- CNT_W, 8, width of the match counter.

Ports:
- iCLK  input  1  system clock.
- iRST_n  input  1  asynchronous active-low reset.
- iIN  input  1  asynchronous serial waveform.
- oSYM  output  1  most recently sampled symbol.
- oMATCH  output  1  one-cycle pulse per complete pattern recognised.
- oLOCK  output  1  high while tracking the pattern symbol-by-symbol.
- oERR  output  1  one-cycle pulse on a symbol mismatch while locked.
- oMATCH_CNT  output  CNT_W  number of matches, saturating.

Behaviour:
- Reset (asynchronous, iRST_n=0):
  - All outputs 0; shift register 0; valid count 0; phase 0; state HUNT.
  - Synchroniser flops reset to 0.
- Input path:
  - iIN passes through a 2-FF synchroniser, then a 1-cycle edge detector.
  - An edge is any change of the synchronised value.
- Timing recovery:
  - Phase counter is $clog2(CLK_PER_SYM) bits wide.
  - Counts 0..CLK_PER_SYM-1, then wraps to 0.
  - Any edge forces phase to 0.
  - A sample is taken in the cycle where phase == CLK_PER_SYM/2-1 and no edge is present. If an edge and the sample point coincide, the edge wins and no sample is taken.
  - Runs of equal symbols (up to 3 in PATTERN) are sampled through the free-running wrap.
- On each sample:
  - oSYM <= sampled value.
  - Shift register: new bit enters at bit 11 and shifts right.
  - Valid count increments, saturating at 12.
- State HUNT:
  - If valid count == 12 and the shift register equals PATTERN, evaluated in the cycle after the sample: pulse oMATCH, go to LOCK, idx <= 0, oLOCK <= 1.
- State LOCK:
  - Each sample is compared with PATTERN[idx].
  - Equal: idx increments. When idx goes 11 -> 0 (a full pattern completed), pulse oMATCH.
  - Mismatch: pulse oERR, go to HUNT, oLOCK <= 0, valid count <= 0.
  - The shift register keeps shifting in both states.
- Latency: oMATCH/oERR are asserted 1 cycle after the sample cycle.
- oMATCH_CNT:
  - Increments on every oMATCH pulse.
  - Saturates at 2^CNT_W-1 and never wraps.
- No edge for 12*CLK_PER_SYM cycles (stuck line): the symbols are sampled as a constant, which mismatches PATTERN, so the block leaves LOCK with oERR.
- Reset mid-operation: asynchronously returns everything to reset values, including the counter.

Optional Feature:
- Macro: PRZEBIEG_GLITCH_FILTER_EN.
- Defined:
  - The synchronised value only propagates to the edge detector after 3 consecutive equal samples.
  - Adds 2 cycles of latency to the edge/sample path.
  - Pulses shorter than 3 cycles are ignored.
- Undefined:
  - Synchroniser output goes directly to the edge detector.
  - Single-cycle glitches resync the phase.

Decomposition:
- Shared package przebieg_pkg holds:
  - PATTERN default 12'hCE8 and PAT_LEN=12, shared with the generator.
  - State enum {HUNT, LOCK}.
- Sub-module przebieg_sync_edge contains the 2-FF synchroniser, the optional glitch filter and the edge detector.
  - Outputs: synchronised level and edge pulse.
- The top level holds phase counter, shift register, FSM and counter.

Test Plan (CLK_PER_SYM=8 for simulation):
- Drive PATTERN repeatedly, 8 cycles/symbol -> first oMATCH about 1 cycle after the 12th sample; oLOCK=1; oMATCH every 96 cycles; oMATCH_CNT=3 after 3 patterns.
- While locked, corrupt symbol 5 (drive 0 instead of 1) -> oERR pulse; oLOCK=0; no oMATCH for that frame; re-match after the next 12 clean symbols.
- Jitter edges by ±2 cycles -> sampling stays mid-symbol; no oERR over 10 patterns.
- Assert iRST_n=0 mid-pattern while locked -> all outputs 0 immediately; after release, oMATCH requires a full 12 new symbols.
- Hold iIN=0 for 200 cycles while locked -> oERR pulse, oLOCK=0, oMATCH_CNT unchanged; drive 300 patterns -> oMATCH_CNT saturates at 255.
- 1-cycle glitch mid-symbol: with PRZEBIEG_GLITCH_FILTER_EN defined -> no oERR; undefined -> phase resync observed; no sample taken in a cycle where the edge coincides with the sample point.

Source files
------------

// File: rtl/przebieg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : przebieg_pkg                                                    |
// | Purpose  : Definitions shared by the 12-step LED waveform generator and    |
// |            its receive-side detector: pattern length, default pattern and  |
// |            the detector state encoding.                                    |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package przebieg_pkg;

  // Number of symbols in one pattern frame.
  localparam int unsigned PAT_LEN = 12;

  // Bit i is symbol i in time order: 0,0,0,1,0,1,1,1,0,0,1,1.
  localparam logic [PAT_LEN-1:0] DEF_PATTERN = 12'hCE8;

  // Detector states.
  typedef enum logic [0:0] {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_e;

endpackage : przebieg_pkg
`default_nettype wire

// File: rtl/przebieg_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : przebieg_sync_edge                                              |
// | Purpose  : 2-FF synchroniser for the asynchronous serial waveform,         |
// |            optional 3-sample glitch filter, and a change detector.         |
// | Ports    : clk_i   - system clock                                          |
// |            rst_ni  - asynchronous active-low reset                         |
// |            in_i    - asynchronous serial input                             |
// |            level_o - synchronised (and optionally filtered) level          |
// |            edge_o  - high in the cycle level_o differs from its last value |
// | Config   : PRZEBIEG_GLITCH_FILTER_EN - when defined, a level change only   |
// |            propagates after 3 consecutive equal synchronised samples       |
// |            (2 extra cycles of latency, pulses < 3 cycles are dropped).     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module przebieg_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_i,
  output logic level_o,
  output logic edge_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic w_level;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= in_i;
      sync_q <= meta_q;
    end
  end

`ifdef PRZEBIEG_GLITCH_FILTER_EN
  logic hist1_q;
  logic hist2_q;
  logic filt_q;
  logic w_stable;

  // The current sample plus two history samples must agree before the
  // filtered level follows; otherwise the last accepted level is held.
  assign w_stable = (sync_q == hist1_q) && (hist1_q == hist2_q);
  assign w_level  = w_stable ? sync_q : filt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist1_q <= 1'b0;
      hist2_q <= 1'b0;
      filt_q  <= 1'b0;
    end else begin
      hist1_q <= sync_q;
      hist2_q <= hist1_q;
      filt_q  <= w_level;
    end
  end
`else
  assign w_level = sync_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= w_level;
    end
  end

  assign level_o = w_level;
  assign edge_o  = w_level ^ prev_q;

endmodule : przebieg_sync_edge
`default_nettype wire

// File: rtl/przebieg_detektor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : przebieg_detektor                                               |
// | Purpose  : Receive side of the 12-step LED waveform link. Recovers symbol  |
// |            timing from edges, samples mid-symbol and recognises PATTERN.   |
// | Ports    : iCLK       - system clock                                       |
// |            iRST_n     - asynchronous active-low reset                      |
// |            iIN        - asynchronous serial waveform                       |
// |            oSYM       - most recently sampled symbol                       |
// |            oMATCH     - one-cycle pulse per complete pattern               |
// |            oLOCK      - high while tracking the pattern symbol-by-symbol   |
// |            oERR       - one-cycle pulse on a symbol mismatch while locked  |
// |            oMATCH_CNT - saturating count of oMATCH pulses                  |
// | Config   : PRZEBIEG_GLITCH_FILTER_EN (see przebieg_sync_edge)              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module przebieg_detektor
  import przebieg_pkg::*;
#(
  parameter int unsigned        CLK_PER_SYM = 2000000,
  parameter logic [PAT_LEN-1:0] PATTERN     = DEF_PATTERN,
  parameter int unsigned        CNT_W       = 8
) (
  input  logic             iCLK,
  input  logic             iRST_n,
  input  logic             iIN,
  output logic             oSYM,
  output logic             oMATCH,
  output logic             oLOCK,
  output logic             oERR,
  output logic [CNT_W-1:0] oMATCH_CNT
);

  localparam int unsigned     PH_W      = $clog2(CLK_PER_SYM);
  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(CLK_PER_SYM - 1);
  localparam logic [PH_W-1:0] PH_SAMPLE = PH_W'(CLK_PER_SYM / 2 - 1);
  localparam int unsigned     VC_W      = $clog2(PAT_LEN + 1);
  localparam logic [VC_W-1:0] VC_FULL   = VC_W'(PAT_LEN);
  localparam int unsigned     IDX_W     = $clog2(PAT_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic w_level;
  logic w_edge;
  logic w_sample;

  state_e             state_q, state_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [PAT_LEN-1:0] shreg_q, shreg_d;
  logic [VC_W-1:0]    vcnt_q,  vcnt_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic               sym_q,   sym_d;
  logic               match_q, match_d;
  logic               err_q,   err_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;

  przebieg_sync_edge u_sync_edge (
    .clk_i   (iCLK),
    .rst_ni  (iRST_n),
    .in_i    (iIN),
    .level_o (w_level),
    .edge_o  (w_edge)
  );

  // Free-running symbol phase, re-zeroed by every edge so the sample point
  // lands half a symbol after the last transition. Runs of equal symbols
  // are covered by the wrap.
  always_comb begin
    phase_d = phase_q + 1'b1;
    if (w_edge || (phase_q == PH_LAST)) begin
      phase_d = '0;
    end
  end

  // An edge at the sample point means timing is being corrected right now;
  // the sample is suppressed rather than taken on a transition.
  assign w_sample = (phase_q == PH_SAMPLE) && !w_edge;

  // All decisions are made in the sample cycle on the new shift-register
  // contents and registered, so oMATCH/oERR appear one cycle later.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    vcnt_d  = vcnt_q;
    idx_d   = idx_q;
    sym_d   = sym_q;
    match_d = 1'b0;
    err_d   = 1'b0;
    if (w_sample) begin
      sym_d   = w_level;
      shreg_d = {w_level, shreg_q[PAT_LEN-1:1]};
      if (vcnt_q != VC_FULL) begin
        vcnt_d = vcnt_q + 1'b1;
      end
      case (state_q)
        HUNT: begin
          if ((vcnt_d == VC_FULL) && (shreg_d == PATTERN)) begin
            match_d = 1'b1;
            state_d = LOCK;
            idx_d   = '0;
          end
        end
        LOCK: begin
          if (w_level == PATTERN[idx_q]) begin
            if (idx_q == IDX_LAST) begin
              idx_d   = '0;
              match_d = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            err_d   = 1'b1;
            state_d = HUNT;
            vcnt_d  = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (match_d && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= HUNT;
      phase_q <= '0;
      shreg_q <= '0;
      vcnt_q  <= '0;
      idx_q   <= '0;
      sym_q   <= 1'b0;
      match_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      shreg_q <= shreg_d;
      vcnt_q  <= vcnt_d;
      idx_q   <= idx_d;
      sym_q   <= sym_d;
      match_q <= match_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign oSYM       = sym_q;
  assign oMATCH     = match_q;
  assign oERR       = err_q;
  assign oLOCK      = (state_q == LOCK);
  assign oMATCH_CNT = cnt_q;

endmodule : przebieg_detektor
`default_nettype wire

// File: tb/tb_przebieg_detektor.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : tb_przebieg_detektor                                            |
// | Purpose  : Directed, table-driven bench for przebieg_detektor with         |
// |            CLK_PER_SYM = 8. Each frame is 96 cycles; pulses are counted by |
// |            a monitor and checked per frame window (window boundary is 4    |
// |            cycles into the following frame). Honours                       |
// |            PRZEBIEG_GLITCH_FILTER_EN for the glitch scenario.              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_przebieg_detektor;

  localparam int          CPS   = 8;
  localparam int          FRAME = 12 * CPS;
  localparam logic [11:0] PAT   = 12'hCE8;
  localparam logic [11:0] PAT_C = 12'hCC8;  // symbol 5 forced to 0

  typedef struct {
    logic [11:0] syms;
    bit          jit;
    int          em;
    int          ee;
    logic        el;
    logic [7:0]  ec;
    logic        es;
  } vec_t;

  logic       r_clk   = 1'b0;
  logic       r_rst_n = 1'b0;
  logic       r_in    = 1'b0;
  logic       w_sym;
  logic       w_match;
  logic       w_lock;
  logic       w_err;
  logic [7:0] w_cnt;

  int n_vec  = 0;
  int n_fail = 0;
  int tot_m  = 0;
  int tot_e  = 0;
  int base_m = 0;
  int base_e = 0;

  vec_t tbl[15];

  przebieg_detektor #(
    .CLK_PER_SYM (CPS),
    .PATTERN     (PAT),
    .CNT_W       (8)
  ) dut (
    .iCLK       (r_clk),
    .iRST_n     (r_rst_n),
    .iIN        (r_in),
    .oSYM       (w_sym),
    .oMATCH     (w_match),
    .oLOCK      (w_lock),
    .oERR       (w_err),
    .oMATCH_CNT (w_cnt)
  );

  always #5 r_clk = ~r_clk;

  always @(negedge r_clk) begin
    if (w_match === 1'b1) tot_m <= tot_m + 1;
    if (w_err === 1'b1)   tot_e <= tot_e + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_win(input string tag, input int em, input int ee,
                           input logic el, input logic [7:0] ec, input logic es);
    chk({tag, ".match_pulses"}, tot_m - base_m, em);
    chk({tag, ".err_pulses"},   tot_e - base_e, ee);
    chk({tag, ".lock"},         {31'd0, w_lock}, {31'd0, el});
    chk({tag, ".match_cnt"},    {24'd0, w_cnt},  {24'd0, ec});
    chk({tag, ".sym"},          {31'd0, w_sym},  {31'd0, es});
    base_m = tot_m;
    base_e = tot_e;
  endtask

  // Edge offsets keep every run long enough for its samples: no +2 edge is
  // directly followed by a -2 edge.
  function automatic int jit_off(input bit jit, input int k);
    if (!jit)   return 0;
    if (k == 3) return 2;
    if (k == 5) return -2;
    if (k == 8) return 2;
    return 0;
  endfunction

  // Drives frame cycles c_lo..c_hi-1; glitch_at inverts one cycle.
  task automatic drive_range(input logic [11:0] syms, input bit jit,
                             input int glitch_at, input int c_lo, input int c_hi);
    for (int c = c_lo; c < c_hi; c++) begin
      int   j;
      logic v;
      j = 0;
      for (int k = 0; k < 12; k++) begin
        if (CPS * k + jit_off(jit, k) <= c) j = k;
      end
      v = syms[j];
      if (c == glitch_at) v = ~v;
      r_in = v;
      @(posedge r_clk);
      #1;
    end
  endtask

  task automatic drive_const(input logic v, input int n);
    repeat (n) begin
      r_in = v;
      @(posedge r_clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Expected per-frame results: pulses in window, then lock/cnt/sym.
    tbl[0] = '{syms: PAT,   jit: 1'b0, em: 1, ee: 0, el: 1'b1, ec: 8'd1, es: 1'b1};
    tbl[1] = '{syms: PAT,   jit: 1'b0, em: 1, ee: 0, el: 1'b1, ec: 8'd2, es: 1'b1};
    tbl[2] = '{syms: PAT,   jit: 1'b0, em: 1, ee: 0, el: 1'b1, ec: 8'd3, es: 1'b1};
    tbl[3] = '{syms: PAT_C, jit: 1'b0, em: 0, ee: 1, el: 1'b0, ec: 8'd3, es: 1'b1};
    tbl[4] = '{syms: PAT,   jit: 1'b0, em: 1, ee: 0, el: 1'b1, ec: 8'd4, es: 1'b1};
    for (int i = 5; i < 15; i++) begin
      tbl[i] = '{syms: PAT, jit: 1'b1, em: 1, ee: 0, el: 1'b1, ec: 8'(i), es: 1'b1};
    end

    // Reset state
    r_rst_n = 1'b0;
    r_in    = 1'b0;
    repeat (3) @(posedge r_clk);
    #1;
    chk("reset.sym",   {31'd0, w_sym},   32'd0);
    chk("reset.match", {31'd0, w_match}, 32'd0);
    chk("reset.lock",  {31'd0, w_lock},  32'd0);
    chk("reset.err",   {31'd0, w_err},   32'd0);
    chk("reset.cnt",   {24'd0, w_cnt},   32'd0);
    r_rst_n = 1'b1;
    drive_const(1'b0, 20);
    base_m = tot_m;
    base_e = tot_e;

    // Table: clean, corrupted, re-acquire, jittered frames
    drive_range(tbl[0].syms, tbl[0].jit, -1, 0, 4);
    for (int i = 0; i < 15; i++) begin
      drive_range(tbl[i].syms, tbl[i].jit, -1, 4, FRAME);
      if (i < 14) drive_range(tbl[i+1].syms, tbl[i+1].jit, -1, 0, 4);
      else        drive_const(1'b0, 4);
      check_win($sformatf("frame%0d", i), tbl[i].em, tbl[i].ee, tbl[i].el, tbl[i].ec, tbl[i].es);
    end

    // Stuck-low line while locked
    drive_const(1'b0, 196);
    check_win("stuck", 0, 1, 1'b0, 8'd14, 1'b0);

    // Re-lock
    drive_range(PAT, 1'b0, -1, 0, FRAME);
    drive_range(PAT, 1'b0, -1, 0, 4);
    check_win("relock", 1, 0, 1'b1, 8'd15, 1'b1);

    // Asynchronous reset mid-frame while locked
    drive_range(PAT, 1'b0, -1, 4, 44);
    r_rst_n = 1'b0;
    #2;
    chk("midreset.sym",   {31'd0, w_sym},   32'd0);
    chk("midreset.match", {31'd0, w_match}, 32'd0);
    chk("midreset.lock",  {31'd0, w_lock},  32'd0);
    chk("midreset.err",   {31'd0, w_err},   32'd0);
    chk("midreset.cnt",   {24'd0, w_cnt},   32'd0);
    drive_range(PAT, 1'b0, -1, 44, 48);
    r_rst_n = 1'b1;
    drive_range(PAT, 1'b0, -1, 48, FRAME);
    drive_range(PAT, 1'b0, -1, 0, 4);
    check_win("after_reset_partial", 0, 0, 1'b0, 8'd0, 1'b1);
    drive_range(PAT, 1'b0, -1, 4, FRAME);
    drive_range(PAT, 1'b0, -1, 0, 4);
    check_win("after_reset_full", 1, 0, 1'b1, 8'd1, 1'b1);

    // Counter saturation: 299 further frames take the count from 1 past 255
    for (int i = 0; i < 299; i++) begin
      drive_range(PAT, 1'b0, -1, 4, FRAME);
      drive_range(PAT, 1'b0, -1, 0, 4);
    end
    check_win("saturate", 299, 0, 1'b1, 8'd255, 1'b1);

    // One-cycle glitch landing on the symbol-2 sample point
    drive_range(PAT, 1'b0, 2 * CPS + 4, 4, FRAME);
    drive_range(PAT, 1'b0, -1, 0, 4);
`ifdef PRZEBIEG_GLITCH_FILTER_EN
    check_win("glitch", 1, 0, 1'b1, 8'd255, 1'b1);
`else
    check_win("glitch", 0, 1, 1'b0, 8'd255, 1'b1);
`endif
    drive_range(PAT, 1'b0, -1, 4, FRAME);
    drive_range(PAT, 1'b0, -1, 0, 4);
    check_win("reacquire", 1, 0, 1'b1, 8'd255, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_przebieg_detektor
`default_nettype wire
